// File: rtl/secure_scrub_fifo.sv
// secure_scrub_fifo: first-word-fall-through FIFO for sensitive data.
// Every entry is zeroized after reset and on every pop. rd_data is forced
// to zero whenever rd_valid is low, so stale words never reach the read port.
// Optional macro SECURE_FIFO_ZEROIZE_EN adds a zeroize input that discards
// all entries and restarts the full wipe.
module secure_scrub_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SECURE_FIFO_ZEROIZE_EN
    input  logic              zeroize,
`endif
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              scrubbing
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {ST_SCRUB = 1'b0, ST_RUN = 1'b1} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] scrub_idx_q, scrub_idx_d;
    logic [CNT_W-1:0]  count_d;
    logic              wr_ready_d, rd_valid_d, scrubbing_d;
    logic              zeroize_req;
    logic              push, pop;

`ifdef SECURE_FIFO_ZEROIZE_EN
    assign zeroize_req = zeroize;
`else
    assign zeroize_req = 1'b0;
`endif

    // Handshakes qualify only in RUN; a zeroize request cancels both sides.
    assign push = (state_q == ST_RUN) && wr_valid && wr_ready && !zeroize_req;
    assign pop  = (state_q == ST_RUN) && rd_valid && rd_ready && !zeroize_req;

    // State register: FSM, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SCRUB;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            scrub_idx_q <= '0;
            count       <= '0;
            wr_ready    <= 1'b0;
            rd_valid    <= 1'b0;
            scrubbing   <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            scrub_idx_q <= scrub_idx_d;
            count       <= count_d;
            wr_ready    <= wr_ready_d;
            rd_valid    <= rd_valid_d;
            scrubbing   <= scrubbing_d;
        end
    end

    // Next-state logic: scrub sweep, zeroize restart, pointer/occupancy update.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        scrub_idx_d = scrub_idx_q;
        count_d     = count;
        case (state_q)
            ST_SCRUB: begin
                scrub_idx_d = scrub_idx_q + ADDR_W'(1);
                if (scrub_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (zeroize_req) begin
                    state_d     = ST_SCRUB;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    scrub_idx_d = '0;
                    count_d     = '0;
                end else begin
                    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    if (push && !pop) begin
                        count_d = count + CNT_W'(1);
                    end else if (pop && !push) begin
                        count_d = count - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_SCRUB;
        endcase
    end

    // Output logic: next values of the registered handshake/status outputs.
    always_comb begin
        scrubbing_d = (state_d == ST_SCRUB);
        wr_ready_d  = (state_d == ST_RUN) && (count_d != CNT_W'(DEPTH));
        rd_valid_d  = (state_d == ST_RUN) && (count_d != '0);
    end

    // Storage: scrub sweep writes zero; in RUN push stores and pop wipes the head.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_SCRUB) begin
                mem[scrub_idx_q] <= '0;
            end else begin
                if (push) mem[wr_ptr_q] <= wr_data;
                if (pop)  mem[rd_ptr_q] <= '0;
            end
        end
    end

    // Head word is exposed only while valid.
    assign rd_data = rd_valid ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_secure_scrub_fifo.sv
// Testbench for secure_scrub_fifo: directed test-plan steps followed by random
// traffic, all checked against a queue-based reference model.
module tb_secure_scrub_fifo;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 4;
`ifdef SECURE_FIFO_ZEROIZE_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              zeroize;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   count;
    logic              scrubbing;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of stored words plus remaining wipe cycles.
    logic [DATA_W-1:0] q[$];
    int                scrub_left = 0;
    bit                model_live = 1'b0;
    bit                watch_cafe = 1'b0;

    always #5 clk = ~clk;

    secure_scrub_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SECURE_FIFO_ZEROIZE_EN
        .zeroize   (zeroize),
`endif
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .count     (count),
        .scrubbing (scrubbing)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model (called at the falling edge).
    task automatic check_outputs();
        int nz;
        if (!model_live) return;
        if (scrub_left > 0) begin
            chk("scrubbing", 32'(scrubbing), 32'd1);
            chk("wr_ready", 32'(wr_ready), 32'd0);
            chk("rd_valid", 32'(rd_valid), 32'd0);
            chk("rd_data", rd_data, 32'd0);
            chk("count", 32'(count), 32'd0);
        end else begin
            chk("scrubbing", 32'(scrubbing), 32'd0);
            chk("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
            chk("rd_valid", 32'(rd_valid), 32'(q.size() > 0));
            chk("rd_data", rd_data, (q.size() > 0) ? q[0] : 32'd0);
            chk("count", 32'(count), 32'(q.size()));
            nz = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (dut.mem[i] !== '0) nz++;
            end
            chk("mem_nonzero_le_occupancy", 32'(nz <= q.size()), 32'd1);
        end
        if (watch_cafe) chk("no_stale_cafe", 32'(rd_data === 32'hCAFEF00D), 32'd0);
    endtask

    // Model reaction to one rising edge, from the inputs held during the cycle.
    task automatic model_edge();
        bit pu, po;
        if (rst) begin
            q.delete();
            scrub_left = DEPTH;
            model_live = 1'b1;
        end else if (!model_live) begin
            // nothing known before the first reset
        end else if (scrub_left > 0) begin
            scrub_left--;
        end else if (ZEN && zeroize) begin
            q.delete();
            scrub_left = DEPTH;
        end else begin
            pu = wr_valid && (q.size() < DEPTH);
            po = rd_ready && (q.size() > 0);
            if (po) void'(q.pop_front());
            if (pu) q.push_back(wr_data);
        end
    endtask

    task automatic cyc();
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic mem_clear(input string tag);
        for (int i = 0; i < DEPTH; i++) chk(tag, dut.mem[i], 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1; zeroize = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        @(negedge clk);

        // 1. Reset for two cycles, then exactly DEPTH scrub cycles.
        cyc();
        cyc();
        rst = 1'b0;
        wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 32'h1234_5678;
        for (int i = 0; i < DEPTH; i++) begin
            chk("scrub_window", 32'(scrubbing), 32'd1);
            cyc();
        end
        wr_valid = 1'b0; rd_ready = 1'b0;
        chk("post_scrub_scrubbing", 32'(scrubbing), 32'd0);
        chk("post_scrub_wr_ready", 32'(wr_ready), 32'd1);
        chk("post_scrub_rd_valid", 32'(rd_valid), 32'd0);
        chk("post_scrub_rd_data", rd_data, 32'd0);
        chk("post_scrub_count", 32'(count), 32'd0);
        mem_clear("mem_after_reset_scrub");

        // 2. Fill to full, blocked 17th push, drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            wr_valid = 1'b1; wr_data = 32'(i);
            cyc();
        end
        chk("full_count", 32'(count), 32'd16);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        wr_data = 32'hFFFF_FFFF;
        cyc();
        wr_valid = 1'b0;
        chk("full_after_blocked_push", 32'(count), 32'd16);
        rd_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_order", rd_data, 32'(i));
            cyc();
        end
        rd_ready = 1'b0;
        chk("drained_rd_valid", 32'(rd_valid), 32'd0);
        chk("drained_rd_data", rd_data, 32'd0);
        mem_clear("mem_after_drain");

        // 3. Five entries, then simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = 32'(100 + i);
            cyc();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data = 32'(200 + i);
            chk("steady_count", 32'(count), 32'd5);
            chk("steady_head", rd_data, (i < 5) ? 32'(100 + i) : 32'(200 + i - 5));
            cyc();
        end
        wr_valid = 1'b0;
        repeat (5) cyc();
        rd_ready = 1'b0;
        chk("steady_empty", 32'(count), 32'd0);

        // 4. Pop wipes the slot it leaves.
        wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
        cyc();
        wr_valid = 1'b0; rd_ready = 1'b1;
        chk("deadbeef_head", rd_data, 32'hDEAD_BEEF);
        cyc();
        rd_ready = 1'b0;
        chk("after_pop_rd_data", rd_data, 32'd0);
        chk("after_pop_rd_valid", 32'(rd_valid), 32'd0);
        mem_clear("mem_after_single_pop");

        // 5. Reset in the middle of traffic.
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1; wr_data = 32'hCAFE_F00D;
            cyc();
        end
        wr_valid = 1'b0; rd_ready = 1'b1; rst = 1'b1;
        cyc();
        rst = 1'b0;
        watch_cafe = 1'b1;
        chk("mid_reset_count", 32'(count), 32'd0);
        repeat (DEPTH) cyc();
        rd_ready = 1'b0;
        chk("mid_reset_scrub_done", 32'(scrubbing), 32'd0);
        mem_clear("mem_after_mid_reset");

`ifdef SECURE_FIFO_ZEROIZE_EN
        // 6. Zeroize drops a same-cycle push and restarts the wipe.
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1; wr_data = 32'(300 + i);
            cyc();
        end
        chk("pre_zeroize_count", 32'(count), 32'd7);
        zeroize = 1'b1; wr_data = 32'h5555_AAAA;
        cyc();
        zeroize = 1'b0; wr_valid = 1'b0;
        chk("zeroize_count", 32'(count), 32'd0);
        chk("zeroize_scrubbing", 32'(scrubbing), 32'd1);
        repeat (8) cyc();
        zeroize = 1'b1;
        cyc();
        zeroize = 1'b0;
        repeat (7) cyc();
        chk("zeroize_scrub_len", 32'(scrubbing), 32'd0);
        mem_clear("mem_after_zeroize");
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            wr_valid = 1'($urandom_range(0, 1));
            rd_ready = 1'($urandom_range(0, 1));
            d = $urandom;
            if (d == 32'hCAFE_F00D) d = 32'h0;
            wr_data = d;
            rst = ($urandom_range(0, 199) == 0);
            zeroize = ($urandom_range(0, 59) == 0);
            cyc();
        end
        rst = 1'b0; zeroize = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
        repeat (2 * DEPTH + 4) cyc();
        chk("final_empty", 32'(count), 32'd0);
        mem_clear("mem_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
